reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Producer-side companion to the ID-stage operand bypass network.
- Tracks destination registers of in-flight multi-cycle operations (integer divide, FP divide/sqrt) that cannot be forwarded from EX/MEM.
- Raises ID-stage stall on RAW/WAW hazards against those registers.
- Clears each entry when the long-latency unit writes back.
- 64-entry unified register space: addr[5]=0 integer x0..x31, addr[5]=1 FP f0..f31; integer x0 (addr 0) is never tracked.

Parameters:
MAX_OUTSTANDING, 4, maximum simultaneously pending multi-cycle destinations (1..63)
EARLY_RELEASE, 1, 1: completing address is treated as not pending for hazard checks in its completion cycle

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
rs1_rena_ID  input  1  rs1 read enable
rs1_addr_ID  input  6  rs1 address
rs2_rena_ID  input  1  rs2 read enable
rs2_addr_ID  input  6  rs2 address
rs3_rena_ID  input  1  rs3 read enable
rs3_addr_ID  input  6  rs3 address
rd_wena_ID  input  1  instruction in ID writes rd
rd_addr_ID  input  6  rd address
issue_mc  input  1  instruction in ID leaves ID this cycle and is multi-cycle (already qualified by valid and not stalled)
done_valid  input  1  multi-cycle unit writes back this cycle
done_addr  input  6  writeback address
pending  output  64  registered pending bitmap
outstanding  output  clog2(MAX_OUTSTANDING+1)  registered count of set pending bits
sb_full  output  1  outstanding == MAX_OUTSTANDING
sb_stall_ID  output  1  combinational ID stall request
sb_error  output  1  sticky protocol-error flag

Behaviour:
- Reset: pending=0, outstanding=0, sb_error=0; sb_full=0 and sb_stall_ID=0 while reset is asserted. Reset mid-operation discards all entries; subsequent done_valid for a discarded entry sets sb_error.
- Effective pending vector eff:
  - equals pending;
  - if EARLY_RELEASE=1 and done_valid, bit done_addr is cleared in eff.
- Hazard terms, each requiring the address to be non-zero:
  - raw_n = rsn_rena_ID && eff[rsn_addr_ID], for n=1,2,3.
  - waw = rd_wena_ID && eff[rd_addr_ID].
  - full_hz = rd_wena_ID && issue-candidate && sb_full. ID drives issue_mc only when not stalled, so the full check uses the current outstanding value minus any same-cycle release.
- sb_stall_ID = raw_1 || raw_2 || raw_3 || waw || full_hz. Purely combinational; no latency.
- Sequential update each rising edge:
  - set = issue_mc && rd_wena_ID && rd_addr_ID!=0
  - clr = done_valid && pending[done_addr]
  - Same address in set and clr in the same cycle: bit ends at 1 (new issue wins).
  - outstanding next = outstanding + set - clr; never wraps.
- Error cases (each sets sb_error, held until reset):
  - done_valid with pending[done_addr]==0, including done_addr==0: no state change.
  - set while outstanding==MAX_OUTSTANDING and not clr: set ignored.
  - set to an address already pending and not cleared this cycle (WAW violation): bit stays 1, count unchanged.
- Invariant: outstanding == popcount(pending) at every edge.
- issue_mc with rd_wena_ID=0 or rd_addr_ID=0: no state change, no error.

Test Plan:
- Reset, then issue_mc rd=0x05 (x5); next cycle rs1=x5 read -> sb_stall_ID=1, pending[5]=1, outstanding=1; done_valid addr 5 -> with EARLY_RELEASE=1, stall drops in the same cycle; pending[5]=0 next edge.
- Issue to f3 (0x23), then ID with rd=0x23 and no reads -> waw stall=1; rs3 reading 0x03 (x3) -> no stall.
- MAX_OUTSTANDING=4: issue to 0x01..0x04 -> sb_full=1; fifth rd_wena_ID -> stall; a done on 0x02 in the same cycle -> stall=0, and issuing 0x06 leaves outstanding=4.
- Same-cycle done_addr=0x07 and issue rd=0x07 -> pending[7]=1, outstanding unchanged, sb_error=0.
- done_valid addr 0x09 with nothing pending -> sb_error=1 and stays 1 until reset; issue_mc rd=0x00 -> no pending bit, outstanding=0.
- Assert reset asynchronously with 3 entries pending -> outputs are zero immediately, before the next clock edge.

Source files
------------

// File: rtl/reg_scoreboard_if.sv
// ID-stage / writeback-side bundle for reg_scoreboard.
// The master side (the ID stage and the long-latency units) drives the
// request fields. The slave side (the scoreboard) drives the status fields.
interface reg_scoreboard_if #(
  parameter int MAX_OUTSTANDING = 4
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic             rs1_rena_ID;
  logic [5:0]       rs1_addr_ID;
  logic             rs2_rena_ID;
  logic [5:0]       rs2_addr_ID;
  logic             rs3_rena_ID;
  logic [5:0]       rs3_addr_ID;
  logic             rd_wena_ID;
  logic [5:0]       rd_addr_ID;
  logic             issue_mc;
  logic             done_valid;
  logic [5:0]       done_addr;
  logic [63:0]      pending;
  logic [CNT_W-1:0] outstanding;
  logic             sb_full;
  logic             sb_stall_ID;
  logic             sb_error;

  modport master (
    output rs1_rena_ID, rs1_addr_ID, rs2_rena_ID, rs2_addr_ID,
           rs3_rena_ID, rs3_addr_ID, rd_wena_ID, rd_addr_ID,
           issue_mc, done_valid, done_addr,
    input  pending, outstanding, sb_full, sb_stall_ID, sb_error
  );

  modport slave (
    input  rs1_rena_ID, rs1_addr_ID, rs2_rena_ID, rs2_addr_ID,
           rs3_rena_ID, rs3_addr_ID, rd_wena_ID, rd_addr_ID,
           issue_mc, done_valid, done_addr,
    output pending, outstanding, sb_full, sb_stall_ID, sb_error
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard for long-latency operations (integer divide, FP div/sqrt).
// The scoreboard keeps one pending bit per register in the unified 64-entry space.
// Addresses 0..31 are x0..x31 and addresses 32..63 are f0..f31.
// Register x0 is never tracked.
// The ID stage is stalled on a RAW or WAW hazard against a pending destination.
// The ID stage is also stalled when a new multi-cycle destination would exceed capacity.
module reg_scoreboard #(
  parameter int MAX_OUTSTANDING = 4,
  parameter bit EARLY_RELEASE   = 1'b1
) (
  input logic            clk,
  input logic            reset,
  reg_scoreboard_if.slave sb
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [63:0]      pending_state;
  logic [CNT_W-1:0] count_state;
  logic             error_state;

  logic [63:0]      eff;
  logic             at_max;
  logic             set_req;
  logic             clr;
  logic             full_block;
  logic             waw_violation;
  logic             set_ok;
  logic             bad_done;
  logic [63:0]      pending_next;
  logic [CNT_W-1:0] count_next;
  logic             raw_1;
  logic             raw_2;
  logic             raw_3;
  logic             waw;
  logic             full_hz;

  assign at_max = (count_state == MAX_CNT);
  assign clr    = sb.done_valid && pending_state[sb.done_addr];

  // Build the hazard view. With early release, a register that completes this
  // cycle is already readable through the writeback bypass, so it is not checked.
  always_comb begin
    eff = pending_state;
    if (EARLY_RELEASE && sb.done_valid) begin
      eff[sb.done_addr] = 1'b0;
    end
  end

  // Compute the stall request. A full scoreboard blocks a new writer only if
  // no entry is released in the same cycle.
  always_comb begin
    raw_1   = sb.rs1_rena_ID && (sb.rs1_addr_ID != 6'd0) && eff[sb.rs1_addr_ID];
    raw_2   = sb.rs2_rena_ID && (sb.rs2_addr_ID != 6'd0) && eff[sb.rs2_addr_ID];
    raw_3   = sb.rs3_rena_ID && (sb.rs3_addr_ID != 6'd0) && eff[sb.rs3_addr_ID];
    waw     = sb.rd_wena_ID && (sb.rd_addr_ID != 6'd0) && eff[sb.rd_addr_ID];
    full_hz = sb.rd_wena_ID && (sb.rd_addr_ID != 6'd0) && at_max && !clr;
  end

  // Qualify the issue and completion events. When a completion and a new issue
  // target the same register, the new issue wins.
  always_comb begin
    set_req       = sb.issue_mc && sb.rd_wena_ID && (sb.rd_addr_ID != 6'd0);
    full_block    = at_max && !clr;
    waw_violation = pending_state[sb.rd_addr_ID] &&
                    !(clr && (sb.done_addr == sb.rd_addr_ID));
    set_ok        = set_req && !full_block && !waw_violation;
    bad_done      = sb.done_valid && !pending_state[sb.done_addr];

    pending_next = pending_state;
    if (clr) begin
      pending_next[sb.done_addr] = 1'b0;
    end
    if (set_ok) begin
      pending_next[sb.rd_addr_ID] = 1'b1;
    end

    count_next = count_state;
    if (set_ok && !clr) begin
      count_next = count_state + CNT_W'(1);
    end else if (clr && !set_ok) begin
      count_next = count_state - CNT_W'(1);
    end
  end

  // Update the bitmap, the count and the sticky error flag. Reset discards every
  // in-flight entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_state <= 64'd0;
      count_state   <= '0;
      error_state   <= 1'b0;
    end else begin
      pending_state <= pending_next;
      count_state   <= count_next;
      if (bad_done || (set_req && (full_block || waw_violation))) begin
        error_state <= 1'b1;
      end
    end
  end

  assign sb.pending     = pending_state;
  assign sb.outstanding = count_state;
  assign sb.sb_error    = error_state;
  assign sb.sb_full     = !reset && at_max;
  assign sb.sb_stall_ID = !reset && (raw_1 || raw_2 || raw_3 || waw || full_hz);
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard with MAX_OUTSTANDING=4 and
// EARLY_RELEASE=1. Expected values are hand-computed constants.
module tb_reg_scoreboard;
  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  reg_scoreboard_if #(.MAX_OUTSTANDING(4)) sb_if ();

  reg_scoreboard #(
    .MAX_OUTSTANDING(4),
    .EARLY_RELEASE(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sb(sb_if)
  );

  // Generate a free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(
    input logic       rs1_en, input logic [5:0] rs1,
    input logic       rs2_en, input logic [5:0] rs2,
    input logic       rs3_en, input logic [5:0] rs3,
    input logic       rd_en,  input logic [5:0] rd,
    input logic       issue,
    input logic       done_v, input logic [5:0] done_a
  );
    sb_if.rs1_rena_ID = rs1_en;
    sb_if.rs1_addr_ID = rs1;
    sb_if.rs2_rena_ID = rs2_en;
    sb_if.rs2_addr_ID = rs2;
    sb_if.rs3_rena_ID = rs3_en;
    sb_if.rs3_addr_ID = rs3;
    sb_if.rd_wena_ID  = rd_en;
    sb_if.rd_addr_ID  = rd;
    sb_if.issue_mc    = issue;
    sb_if.done_valid  = done_v;
    sb_if.done_addr   = done_a;
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 6'd0, 0, 6'd0, 0, 6'd0, 0, 6'd0, 0, 0, 6'd0);
  endtask

  task automatic issue(input logic [5:0] rd);
    applyStimulus(0, 6'd0, 0, 6'd0, 0, 6'd0, 1, rd, 1, 0, 6'd0);
  endtask

  task automatic done(input logic [5:0] a);
    applyStimulus(0, 6'd0, 0, 6'd0, 0, 6'd0, 0, 6'd0, 0, 1, a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    idle();
    tick();
    tick();
    checkOutput("reset_pending", sb_if.pending, 64'd0);
    checkOutput("reset_outstanding", 64'(sb_if.outstanding), 64'd0);
    checkOutput("reset_error", 64'(sb_if.sb_error), 64'd0);
    checkOutput("reset_full", 64'(sb_if.sb_full), 64'd0);
    checkOutput("reset_stall", 64'(sb_if.sb_stall_ID), 64'd0);
    reset = 1'b0;
    tick();

    // Issue to x5, RAW on rs1, then early release when x5 completes.
    issue(6'h05);
    checkOutput("issue_x5_no_stall", 64'(sb_if.sb_stall_ID), 64'd0);
    tick();
    checkOutput("x5_pending", sb_if.pending, 64'h20);
    checkOutput("x5_outstanding", 64'(sb_if.outstanding), 64'd1);
    applyStimulus(1, 6'h05, 0, 6'd0, 0, 6'd0, 0, 6'd0, 0, 0, 6'd0);
    checkOutput("raw_rs1_x5", 64'(sb_if.sb_stall_ID), 64'd1);
    applyStimulus(1, 6'h05, 0, 6'd0, 0, 6'd0, 0, 6'd0, 0, 1, 6'h05);
    checkOutput("early_release_x5", 64'(sb_if.sb_stall_ID), 64'd0);
    tick();
    checkOutput("x5_cleared", sb_if.pending, 64'd0);
    checkOutput("x5_count_zero", 64'(sb_if.outstanding), 64'd0);

    // Issue to f3 (0x23). A WAW check on 0x23 must stall. A read of x3 must not.
    issue(6'h23);
    tick();
    checkOutput("f3_pending", sb_if.pending, 64'h0000_0008_0000_0000);
    applyStimulus(0, 6'd0, 0, 6'd0, 0, 6'd0, 1, 6'h23, 0, 0, 6'd0);
    checkOutput("waw_f3", 64'(sb_if.sb_stall_ID), 64'd1);
    applyStimulus(0, 6'd0, 0, 6'd0, 1, 6'h03, 0, 6'd0, 0, 0, 6'd0);
    checkOutput("rs3_x3_no_stall", 64'(sb_if.sb_stall_ID), 64'd0);
    applyStimulus(0, 6'd0, 1, 6'h23, 0, 6'd0, 0, 6'd0, 0, 0, 6'd0);
    checkOutput("raw_rs2_f3", 64'(sb_if.sb_stall_ID), 64'd1);
    done(6'h23);
    tick();
    checkOutput("f3_cleared", sb_if.pending, 64'd0);

    // Fill the scoreboard, then test the full stall and release-while-full.
    issue(6'h01); tick();
    issue(6'h02); tick();
    issue(6'h03); tick();
    issue(6'h04); tick();
    idle();
    checkOutput("fill_pending", sb_if.pending, 64'h1E);
    checkOutput("fill_outstanding", 64'(sb_if.outstanding), 64'd4);
    checkOutput("fill_full", 64'(sb_if.sb_full), 64'd1);
    applyStimulus(0, 6'd0, 0, 6'd0, 0, 6'd0, 1, 6'h06, 0, 0, 6'd0);
    checkOutput("full_stall", 64'(sb_if.sb_stall_ID), 64'd1);
    applyStimulus(0, 6'd0, 0, 6'd0, 0, 6'd0, 1, 6'h06, 0, 1, 6'h02);
    checkOutput("full_release_no_stall", 64'(sb_if.sb_stall_ID), 64'd0);
    applyStimulus(0, 6'd0, 0, 6'd0, 0, 6'd0, 1, 6'h06, 1, 1, 6'h02);
    tick();
    idle();
    checkOutput("swap_pending", sb_if.pending, 64'h5A);
    checkOutput("swap_outstanding", 64'(sb_if.outstanding), 64'd4);
    checkOutput("swap_no_error", 64'(sb_if.sb_error), 64'd0);
    done(6'h01); tick();
    done(6'h03); tick();
    done(6'h04); tick();
    done(6'h06); tick();
    idle();
    checkOutput("drain_pending", sb_if.pending, 64'd0);
    checkOutput("drain_outstanding", 64'(sb_if.outstanding), 64'd0);
    checkOutput("drain_full", 64'(sb_if.sb_full), 64'd0);

    // An issue without a register write changes nothing and is not an error.
    applyStimulus(0, 6'd0, 0, 6'd0, 0, 6'd0, 0, 6'h08, 1, 0, 6'd0);
    tick();
    idle();
    checkOutput("no_wena_pending", sb_if.pending, 64'd0);
    checkOutput("no_wena_error", 64'(sb_if.sb_error), 64'd0);

    // A completion and a new issue to the same register: the new issue wins.
    issue(6'h07);
    tick();
    applyStimulus(0, 6'd0, 0, 6'd0, 0, 6'd0, 1, 6'h07, 1, 1, 6'h07);
    tick();
    idle();
    checkOutput("same_addr_pending", sb_if.pending, 64'h80);
    checkOutput("same_addr_outstanding", 64'(sb_if.outstanding), 64'd1);
    checkOutput("same_addr_error", 64'(sb_if.sb_error), 64'd0);
    done(6'h07);
    tick();
    idle();
    checkOutput("x7_cleared", sb_if.pending, 64'd0);

    // A stray completion sets the sticky error. An issue to x0 is ignored.
    done(6'h09);
    tick();
    idle();
    checkOutput("stray_done_error", 64'(sb_if.sb_error), 64'd1);
    issue(6'h00);
    tick();
    idle();
    checkOutput("x0_pending", sb_if.pending, 64'd0);
    checkOutput("x0_outstanding", 64'(sb_if.outstanding), 64'd0);
    tick();
    checkOutput("error_sticky", 64'(sb_if.sb_error), 64'd1);

    // Issuing past capacity is ignored and flagged.
    pulseReset();
    checkOutput("reset_clears_error", 64'(sb_if.sb_error), 64'd0);
    issue(6'h11); tick();
    issue(6'h12); tick();
    issue(6'h13); tick();
    issue(6'h14); tick();
    issue(6'h15); tick();
    idle();
    checkOutput("overfill_pending", sb_if.pending, 64'h001E_0000);
    checkOutput("overfill_outstanding", 64'(sb_if.outstanding), 64'd4);
    checkOutput("overfill_error", 64'(sb_if.sb_error), 64'd1);

    // Reissuing to a register that is already pending is a WAW violation.
    pulseReset();
    issue(6'h10); tick();
    issue(6'h10); tick();
    idle();
    checkOutput("waw_violation_pending", sb_if.pending, 64'h0001_0000);
    checkOutput("waw_violation_outstanding", 64'(sb_if.outstanding), 64'd1);
    checkOutput("waw_violation_error", 64'(sb_if.sb_error), 64'd1);

    // Asserting reset between clock edges clears outputs at once.
    pulseReset();
    issue(6'h21); tick();
    issue(6'h22); tick();
    issue(6'h0A); tick();
    applyStimulus(1, 6'h21, 0, 6'd0, 0, 6'd0, 0, 6'd0, 0, 0, 6'd0);
    checkOutput("pre_reset_outstanding", 64'(sb_if.outstanding), 64'd3);
    checkOutput("pre_reset_stall", 64'(sb_if.sb_stall_ID), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_pending", sb_if.pending, 64'd0);
    checkOutput("async_reset_outstanding", 64'(sb_if.outstanding), 64'd0);
    checkOutput("async_reset_stall", 64'(sb_if.sb_stall_ID), 64'd0);
    checkOutput("async_reset_full", 64'(sb_if.sb_full), 64'd0);
    reset = 1'b0;
    tick();
    done(6'h21);
    tick();
    idle();
    checkOutput("discarded_done_error", 64'(sb_if.sb_error), 64'd1);
    checkOutput("discarded_done_pending", sb_if.pending, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
